// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory/write-back stage: op encodings,
// CPSR flag positions and datapath widths.
package mem_stage_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } ex_op_t;

  // CPSR bit positions within {N,C,Z,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mem_stage_timeout_counter.sv
// Cycle counter for an outstanding memory request; flags the last permitted
// MEM cycle. Built only when MEM_STAGE_TIMEOUT_EN is defined.
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // The edge that would bring the count to LIMIT is the abort edge.
  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access / write-back stage with CPSR ownership and a req/ack data port.
// Optional request timeout with sticky fault: define MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [DATA_W:0]   ex_result,
  input  logic              ex_w_enable,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic [31:0]       ex_pointer,
  input  logic [15:0]       ex_offset,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [3:0]        ex_flags,
  input  logic              ex_flags_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [15:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        cpsr,
  output logic              mem_fault
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t           state;
  logic [REG_W-1:0] dest_q;
  logic             transfer;

  assign ex_ready = (state == IDLE);
  assign transfer = ex_valid && ex_ready;

  // Carry and the upper pointer half never reach the register file or the bus.
  logic unused_bits;
  assign unused_bits = ^{ex_result[DATA_W], ex_pointer[31:16]};

`ifdef MEM_STAGE_TIMEOUT_EN
  logic timeout;

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state == MEM && !dmem_ack),
    .expired(timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign mem_fault = 1'b0;
`endif

  // NOTE: async reset clears dmem_req the moment rst rises, so a pending
  // request is withdrawn without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dest_q     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_en      <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      cpsr       <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      mem_fault  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout; the default below is overridden later
      // in the same block, giving a one-cycle write strobe without a latch.
      wb_en <= 1'b0;
      if (transfer && ex_flags_we) cpsr <= ex_flags;

      case (state)
        IDLE: begin
          if (ex_valid) begin
            case (ex_op)
              OP_ALU: begin
                if (ex_w_enable) begin
                  wb_en   <= 1'b1;
                  wb_reg  <= ex_dest_reg;
                  wb_data <= ex_result[DATA_W-1:0];
                end
              end
              OP_LOAD, OP_STORE: begin
                dmem_req   <= 1'b1;
                dmem_we    <= (ex_op == OP_STORE);
                // 16-bit add of a 16-bit signed offset wraps modulo 2^16.
                dmem_addr  <= ex_pointer[15:0] + ex_offset;
                dmem_wdata <= ex_store_data;
                dest_q     <= ex_dest_reg;
                state      <= MEM;
              end
              default: ;
            endcase
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            if (!dmem_we) begin
              wb_en   <= 1'b1;
              wb_reg  <= dest_q;
              wb_data <= dmem_rdata;
            end
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          else if (timeout) begin
            dmem_req  <= 1'b0;
            state     <= IDLE;
            mem_fault <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed memory sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic [32:0] ex_result;
  logic        ex_w_enable;
  logic [2:0]  ex_dest_reg;
  logic [31:0] ex_pointer;
  logic [15:0] ex_offset;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_flags;
  logic        ex_flags_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  cpsr;
  logic        mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_result(ex_result), .ex_w_enable(ex_w_enable), .ex_dest_reg(ex_dest_reg),
    .ex_pointer(ex_pointer), .ex_offset(ex_offset), .ex_store_data(ex_store_data),
    .ex_flags(ex_flags), .ex_flags_we(ex_flags_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .cpsr(cpsr), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_op = OP_NOP; ex_result = '0; ex_w_enable = 0;
    ex_dest_reg = 0; ex_pointer = 0; ex_offset = 0; ex_store_data = 0;
    ex_flags = 0; ex_flags_we = 0;
  endtask

  task automatic drive_random();
    ex_valid      = 1'($urandom_range(0, 1));
    ex_op         = 2'($urandom_range(0, 3));
    ex_result     = {1'($urandom), 32'($urandom)};
    ex_w_enable   = 1'($urandom);
    ex_dest_reg   = 3'($urandom);
    ex_pointer    = 32'($urandom);
    ex_offset     = 16'($urandom);
    ex_store_data = 32'($urandom);
    ex_flags      = 4'($urandom);
    ex_flags_we   = 1'($urandom);
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [32:0] result;
    logic        w_en;
    logic [2:0]  dest;
    logic [3:0]  flags;
    logic        flags_we;
    logic        exp_wb;
    logic [2:0]  exp_reg;
    logic [31:0] exp_data;
    logic [3:0]  exp_cpsr;
  } vec_t;

  vec_t vecs[7];

  // Reference model state
  logic [3:0]  cpsr_m;
  logic [31:0] mem_m [int];

  function automatic int wrap_addr(input logic [31:0] ptr, input logic [15:0] off);
    int s;
    s = int'(ptr[15:0]) + int'($signed(off));
    return ((s % 65536) + 65536) % 65536;
  endfunction

  initial begin
    int a_exp;
    int d;
    logic        is_load;
    logic [2:0]  dst;
    logic [31:0] sd;
    logic        exp_wb;
    logic [2:0]  exp_reg;
    logic [31:0] exp_data;

    vecs[0] = '{1, OP_ALU, 33'h1_0000_0005, 1, 3, 4'b0110, 1, 1, 3, 32'h5,         4'b0110};
    vecs[1] = '{1, OP_NOP, 33'h0_1234_5678, 1, 5, 4'b1001, 0, 0, 0, 32'h0,         4'b0110};
    vecs[2] = '{1, OP_NOP, 33'h0_0000_0000, 0, 5, 4'b1001, 1, 0, 0, 32'h0,         4'b1001};
    vecs[3] = '{1, OP_ALU, 33'h0_0000_0007, 0, 2, 4'b1111, 0, 0, 0, 32'h0,         4'b1001};
    vecs[4] = '{1, OP_ALU, 33'h0_FFFF_FFFF, 1, 7, 4'b0000, 1, 1, 7, 32'hFFFF_FFFF, 4'b0000};
    vecs[5] = '{1, OP_ALU, 33'h1_8000_0000, 1, 0, 4'b1100, 1, 1, 0, 32'h8000_0000, 4'b1100};
    vecs[6] = '{0, OP_ALU, 33'h0_0000_0011, 1, 1, 4'b0011, 1, 0, 0, 32'h0,         4'b1100};

    idle_inputs();
    dmem_ack = 0; dmem_rdata = 0;
    rst = 1;
    #12;
    check("rst_wb_en", 64'(wb_en), 0);
    check("rst_req", 64'(dmem_req), 0);
    check("rst_addr", 64'(dmem_addr), 0);
    check("rst_cpsr", 64'(cpsr), 0);
    check("rst_fault", 64'(mem_fault), 0);
    check("rst_ready", 64'(ex_ready), 1);
    @(posedge clk); #1;
    rst = 0;

    // Single-cycle ops with ex_valid held high: one op per cycle
    for (int i = 0; i < 7; i++) begin
      ex_valid = vecs[i].valid; ex_op = vecs[i].op; ex_result = vecs[i].result;
      ex_w_enable = vecs[i].w_en; ex_dest_reg = vecs[i].dest;
      ex_flags = vecs[i].flags; ex_flags_we = vecs[i].flags_we;
      tick();
      check($sformatf("vec%0d_wb_en", i), 64'(wb_en), 64'(vecs[i].exp_wb));
      if (vecs[i].exp_wb) begin
        check($sformatf("vec%0d_wb_reg", i), 64'(wb_reg), 64'(vecs[i].exp_reg));
        check($sformatf("vec%0d_wb_data", i), 64'(wb_data), 64'(vecs[i].exp_data));
      end
      check($sformatf("vec%0d_cpsr", i), 64'(cpsr), 64'(vecs[i].exp_cpsr));
      check($sformatf("vec%0d_ready", i), 64'(ex_ready), 1);
    end

    // LOAD with negative offset, ack on the third MEM cycle
    idle_inputs();
    ex_valid = 1; ex_op = OP_LOAD; ex_pointer = 32'h0000_0010; ex_offset = 16'hFFFC;
    ex_dest_reg = 4; ex_flags = 4'b1010; ex_flags_we = 1;
    tick();
    check("ld_req", 64'(dmem_req), 1);
    check("ld_addr", 64'(dmem_addr), 64'h000C);
    check("ld_we", 64'(dmem_we), 0);
    check("ld_cpsr", 64'(cpsr), 64'b1010);
    ex_op = OP_ALU; ex_w_enable = 1; ex_flags = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("ld_hold_ready", 64'(ex_ready), 0);
      check("ld_hold_req", 64'(dmem_req), 1);
      check("ld_hold_wb", 64'(wb_en), 0);
    end
    ex_valid = 0;
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 0;
    check("ld_wb_en", 64'(wb_en), 1);
    check("ld_wb_reg", 64'(wb_reg), 4);
    check("ld_wb_data", 64'(wb_data), 64'hDEADBEEF);
    check("ld_req_drop", 64'(dmem_req), 0);
    check("ld_ready", 64'(ex_ready), 1);
    check("ld_cpsr_kept", 64'(cpsr), 64'b1010);
    tick();
    check("ld_wb_once", 64'(wb_en), 0);

    // Spurious ack while idle, then ack already high as the request rises
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'h1357_9BDF;
    tick();
    check("spur_wb", 64'(wb_en), 0);
    check("spur_req", 64'(dmem_req), 0);
    ex_valid = 1; ex_op = OP_LOAD; ex_pointer = 32'h0000_0100; ex_offset = 16'h0004;
    ex_dest_reg = 2;
    tick();
    ex_valid = 0;
    check("fast_req", 64'(dmem_req), 1);
    tick();
    dmem_ack = 0;
    check("fast_wb_en", 64'(wb_en), 1);
    check("fast_wb_data", 64'(wb_data), 64'h1357_9BDF);

    // STORE with address wrap; bus held stable while upstream inputs change
    idle_inputs();
    ex_valid = 1; ex_op = OP_STORE; ex_pointer = 32'h0000_FFFF; ex_offset = 16'h0002;
    ex_store_data = 32'hA5A5_1234; ex_dest_reg = 6;
    tick();
    ex_pointer = 32'h1234_5678; ex_store_data = 32'h0BAD_F00D; ex_offset = 16'h7777;
    check("st_addr", 64'(dmem_addr), 64'h0001);
    check("st_we", 64'(dmem_we), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("st_hold_addr", 64'(dmem_addr), 64'h0001);
      check("st_hold_wdata", 64'(dmem_wdata), 64'hA5A5_1234);
      check("st_hold_req", 64'(dmem_req), 1);
    end
    ex_valid = 0;
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    check("st_req_drop", 64'(dmem_req), 0);
    check("st_no_wb", 64'(wb_en), 0);

    // Reset asserted mid-LOAD
    idle_inputs();
    ex_valid = 1; ex_op = OP_LOAD; ex_pointer = 32'h20; ex_dest_reg = 1;
    ex_flags = 4'b0101; ex_flags_we = 1;
    tick();
    idle_inputs();
    check("rl_req", 64'(dmem_req), 1);
    check("rl_cpsr", 64'(cpsr), 64'b0101);
    rst = 1;
    #1;
    check("rl_req_async", 64'(dmem_req), 0);
    check("rl_cpsr_clr", 64'(cpsr), 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_0000;
    tick();
    dmem_ack = 0; rst = 0;
    tick();
    check("rl_no_wb", 64'(wb_en), 0);
    check("rl_ready", 64'(ex_ready), 1);
    check("rl_req_low", 64'(dmem_req), 0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // LOAD never acked: abort after TIMEOUT_CYCLES (4) MEM cycles
    ex_valid = 1; ex_op = OP_LOAD; ex_pointer = 32'h40; ex_dest_reg = 3;
    tick();
    ex_valid = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_req_held", 64'(dmem_req), 1);
    end
    tick();
    check("to_req_drop", 64'(dmem_req), 0);
    check("to_fault", 64'(mem_fault), 1);
    check("to_no_wb", 64'(wb_en), 0);
    check("to_ready", 64'(ex_ready), 1);
    ex_valid = 1; ex_op = OP_ALU; ex_w_enable = 1; ex_dest_reg = 5; ex_result = 33'h77;
    tick();
    idle_inputs();
    check("to_alu_wb", 64'(wb_en), 1);
    check("to_alu_data", 64'(wb_data), 64'h77);
    check("to_fault_sticky", 64'(mem_fault), 1);
`else
    check("no_fault", 64'(mem_fault), 0);
`endif

    // Randomized run against the transaction-level model
    cpsr_m = 4'b0000;
    for (int k = 0; k < 300; k++) begin
      drive_random();
      if (ex_valid && ex_flags_we) cpsr_m = ex_flags;
      if (ex_valid && (ex_op == OP_LOAD || ex_op == OP_STORE)) begin
        a_exp = wrap_addr(ex_pointer, ex_offset);
        is_load = (ex_op == OP_LOAD);
        dst = ex_dest_reg;
        sd = ex_store_data;
        tick();
        check("rnd_req", 64'(dmem_req), 1);
        check("rnd_addr", 64'(dmem_addr), 64'(a_exp));
        check("rnd_we", 64'(dmem_we), 64'(!is_load));
        if (!is_load) check("rnd_wdata", 64'(dmem_wdata), 64'(sd));
        d = $urandom_range(0, 3);
        for (int c = 0; c < d; c++) begin
          drive_random();
          tick();
          check("rnd_hold_req", 64'(dmem_req), 1);
          check("rnd_hold_addr", 64'(dmem_addr), 64'(a_exp));
          check("rnd_hold_cpsr", 64'(cpsr), 64'(cpsr_m));
        end
        ex_valid = 0;
        if (is_load && !mem_m.exists(a_exp)) mem_m[a_exp] = 32'($urandom);
        if (!is_load) mem_m[a_exp] = sd;
        dmem_rdata = is_load ? mem_m[a_exp] : 32'($urandom);
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        check("rnd_req_drop", 64'(dmem_req), 0);
        check("rnd_mem_wb_en", 64'(wb_en), 64'(is_load));
        if (is_load) begin
          check("rnd_ld_reg", 64'(wb_reg), 64'(dst));
          check("rnd_ld_data", 64'(wb_data), 64'(mem_m[a_exp]));
        end
      end else begin
        exp_wb   = ex_valid && (ex_op == OP_ALU) && ex_w_enable;
        exp_reg  = ex_dest_reg;
        exp_data = ex_result[31:0];
        tick();
        check("rnd_wb_en", 64'(wb_en), 64'(exp_wb));
        if (exp_wb) begin
          check("rnd_wb_reg", 64'(wb_reg), 64'(exp_reg));
          check("rnd_wb_data", 64'(wb_data), 64'(exp_data));
        end
        check("rnd_ready", 64'(ex_ready), 1);
      end
      check("rnd_cpsr", 64'(cpsr), 64'(cpsr_m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access/write-back stage that sits directly downstream of the execute stage. It takes one EX result per handshake and does one of three things: writes an ALU result back, performs a load or store through a req/ack data-memory port, or retires a NOP. It owns the architectural CPSR flag register (N,C,Z,V) and stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in MEM before abort (used only with MEM_STAGE_TIMEOUT_EN).

Ports:
- clk  in  1  stage clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents an operation
- ex_ready  out  1  stage accepts this cycle; transfer = ex_valid & ex_ready
- ex_op  in  2  00 ALU write-back, 01 LOAD, 10 STORE, 11 NOP
- ex_result  in  33  ALU result; bit 32 is carry and is not written back
- ex_w_enable  in  1  ALU result is written to ex_dest_reg
- ex_dest_reg  in  3  destination register (ALU and LOAD)
- ex_pointer  in  32  base pointer register value
- ex_offset  in  16  signed offset
- ex_store_data  in  32  store data
- ex_flags  in  4  new flags, order {N,C,Z,V}
- ex_flags_we  in  1  update CPSR from ex_flags
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  16  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes request
- dmem_rdata  in  32  load data, valid with dmem_ack
- wb_en  out  1  register-file write strobe, one cycle
- wb_reg  out  3  register-file write address
- wb_data  out  32  register-file write data
- cpsr  out  4  {N,C,Z,V}
- mem_fault  out  1  sticky timeout fault

## Operation
- FSM has two states: IDLE and MEM. ex_ready = (state == IDLE).
- Reset values: state IDLE; all outputs 0, including cpsr = 4'b0000 and mem_fault = 0.
- Transfer with ALU op: if ex_w_enable, register wb_en=1, wb_reg=ex_dest_reg, wb_data=ex_result[31:0]. State stays IDLE.
- Transfer with NOP: no write-back.
- CPSR: on any transfer with ex_flags_we=1, cpsr <= ex_flags, whatever ex_op is. CPSR is not modified at any other time.
- Transfer with LOAD or STORE:
  - Capture dmem_addr = ex_pointer[15:0] + sign-extended ex_offset, modulo 2^16; a result past 16'hFFFF wraps to 16'h0000.
  - Capture dmem_we, dmem_wdata = ex_store_data, and the destination register.
  - Set dmem_req=1 and go to MEM.
- In MEM: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack.
  - dmem_ack=1 on a LOAD: register wb_en=1, wb_reg=captured destination, wb_data=dmem_rdata; drop dmem_req; go to IDLE.
  - dmem_ack=1 on a STORE: drop dmem_req; go to IDLE; no write-back.
- dmem_ack is ignored while dmem_req=0.
- wb_en is 0 in every cycle not described above. wb_reg and wb_data hold their last values.
- Reset asserted in MEM: dmem_req drops immediately (asynchronously), the pending write-back is discarded, and the FSM returns to IDLE.

## Timing
- ALU op transferred at edge N: wb_en high during cycle N+1. Throughput is one op per cycle.
- LOAD/STORE transferred at edge N: dmem_req high from cycle N+1.
- dmem_ack sampled high at edge M:
  - dmem_req low from cycle M+1.
  - LOAD: wb_en high in cycle M+1.
  - ex_ready high in cycle M+1, so back-to-back memory ops have one idle request cycle between them.
- Minimum load latency: 2 cycles from transfer to wb_en, when ack arrives in the first MEM cycle.
- An ack in the same cycle dmem_req first rises counts as completion.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A counter clears on entry to MEM and increments each MEM cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop dmem_req, return to IDLE, suppress the load write-back, and set mem_fault=1 until reset.
  - An ack on the same edge the counter reaches the limit wins; no fault is raised.
- MEM_STAGE_TIMEOUT_EN undefined: no counter is built, mem_fault is tied 0, and MEM waits for ack indefinitely.

## Structure
- Shared CPU package holds:
  - ex_op encodings: OP_ALU, OP_LOAD, OP_STORE, OP_NOP.
  - CPSR bit indices: FLAG_N=3, FLAG_C=2, FLAG_Z=1, FLAG_V=0.
  - Register-address width (3) and data width (32).
- The FSM state typedef stays local to this block.
- One sub-module: mem_timeout_counter, instantiated only under MEM_STAGE_TIMEOUT_EN.

## Test plan
- ALU op, ex_result=33'h1_0000_0005, ex_w_enable=1, ex_dest_reg=3, ex_flags_we=1, ex_flags=4'b0110 → next cycle wb_en=1, wb_reg=3, wb_data=32'h5; cpsr=4'b0110.
- LOAD, ex_pointer=32'h0000_0010, ex_offset=16'hFFFC → dmem_addr=16'h000C, dmem_we=0. Ack after 3 cycles with dmem_rdata=32'hDEADBEEF → wb_en one cycle later with that data; ex_ready low throughout MEM.
- STORE, ex_pointer=32'h0000_FFFF, ex_offset=16'h0002 → dmem_addr=16'h0001 (wrap), dmem_wdata held stable until ack; no wb_en.
- Spurious dmem_ack while IDLE, then rst asserted mid-LOAD → no wb_en; dmem_req drops in the reset cycle; cpsr=0 after reset.
- Three back-to-back ALU ops with ex_valid held high → three consecutive wb_en cycles, ex_ready never low.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, LOAD never acked → dmem_req drops after 4 MEM cycles, mem_fault=1 and stays high, no wb_en; the next ALU op is accepted.
